alu: RTL and testbench

- 16-bit registered arithmetic/logic unit used by the CPU core.
- Each cycle it samples operands a/b, the 8-bit operation code op and the incoming carry cf.
- It produces a 16-bit result acc, an auxiliary high/remainder word c, and carry/zero/overflow flags.
- The CPU presents operands, waits, then copies acc/c/flags into its registers.

---
 rtl/alu.sv | 161 ++++++++++++++++
 tb/tb_alu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 16-bit ALU: operands, op and carry-in are sampled on each rising clk and
// acc/c/flags update in the same edge. Undefined opcodes leave every output unchanged.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       op,
  input  logic             cf,
  output logic             c_flag,
  output logic             z_flag,
  output logic             o_flag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] c
);
  localparam int H = WIDTH / 2;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_ADC  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_SUC  = 8'h04;
  localparam logic [7:0] OP_MUL8 = 8'h05;
  localparam logic [7:0] OP_MUL6 = 8'h06;
  localparam logic [7:0] OP_DIV8 = 8'h07;
  localparam logic [7:0] OP_DIV6 = 8'h08;
  localparam logic [7:0] OP_CMP  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_NEG  = 8'h0B;
  localparam logic [7:0] OP_NOT  = 8'h0C;
  localparam logic [7:0] OP_OR   = 8'h0D;
  localparam logic [7:0] OP_SHL  = 8'h0E;
  localparam logic [7:0] OP_SHR  = 8'h0F;
  localparam logic [7:0] OP_XOR  = 8'h10;
  localparam logic [7:0] OP_TEST = 8'h11;

  logic [WIDTH-1:0]   acc_q, acc_d, c_q, c_d;
  logic               c_flag_q, c_flag_d, z_flag_q, z_flag_d, o_flag_q, o_flag_d;
  logic               acc_wr;
  logic               cin, bin;
  logic [WIDTH:0]     add_r, sub_r;
  logic               add_ovf, sub_ovf;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul8;
  logic [WIDTH-1:0]   div_b, quo16, rem16;
  logic [H-1:0]       div8_b, quo8, rem8;

  // Signed overflow of an addition: same-sign operands giving a different-sign result.
  function automatic logic add_overflow(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  always_comb begin
    cin     = (op == OP_ADC) & cf;
    bin     = (op == OP_SUC) & cf;
    add_r   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_r   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    add_ovf = add_overflow(a[WIDTH-1], b[WIDTH-1], add_r[WIDTH-1]);
    sub_ovf = add_overflow(a[WIDTH-1], ~b[WIDTH-1], sub_r[WIDTH-1]);
    prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    mul8    = {{H{1'b0}}, a[H-1:0]} * {{H{1'b0}}, b[H-1:0]};
    // Divisors forced non-zero so the dividers never see /0; those results are overridden.
    div_b   = (b == '0) ? WIDTH'(1) : b;
    quo16   = a / div_b;
    rem16   = a % div_b;
    div8_b  = (b[H-1:0] == '0) ? H'(1) : b[H-1:0];
    quo8    = a[H-1:0] / div8_b;
    rem8    = a[H-1:0] % div8_b;
  end

  always_comb begin
    acc_d    = acc_q;
    c_d      = c_q;
    c_flag_d = c_flag_q;
    z_flag_d = z_flag_q;
    o_flag_d = o_flag_q;
    acc_wr   = 1'b1;
    case (op)
      OP_ADD, OP_ADC: begin
        acc_d = add_r[WIDTH-1:0]; c_d = '0; c_flag_d = add_r[WIDTH]; o_flag_d = add_ovf;
      end
      OP_SUB, OP_SUC: begin
        acc_d = sub_r[WIDTH-1:0]; c_d = '0; c_flag_d = sub_r[WIDTH]; o_flag_d = sub_ovf;
      end
      OP_CMP: begin
        acc_wr   = 1'b0;
        c_flag_d = sub_r[WIDTH];
        o_flag_d = sub_ovf;
        z_flag_d = (sub_r[WIDTH-1:0] == '0);
      end
      OP_MUL8: begin
        acc_d = mul8; c_d = '0; c_flag_d = 1'b0; o_flag_d = 1'b0;
      end
      OP_MUL6: begin
        acc_d    = prod[WIDTH-1:0];
        c_d      = prod[2*WIDTH-1:WIDTH];
        c_flag_d = (prod[2*WIDTH-1:WIDTH] != '0);
        o_flag_d = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      OP_DIV8: begin
        c_d      = '0;
        c_flag_d = 1'b0;
        o_flag_d = (b[H-1:0] == '0);
        acc_d    = (b[H-1:0] == '0) ? {a[H-1:0], {H{1'b1}}} : {rem8, quo8};
      end
      OP_DIV6: begin
        c_flag_d = 1'b0;
        o_flag_d = (b == '0);
        acc_d    = (b == '0) ? '1 : quo16;
        c_d      = (b == '0) ? a : rem16;
      end
      OP_AND: begin acc_d = a & b; c_d = '0; c_flag_d = 1'b0; o_flag_d = 1'b0; end
      OP_NOT: begin acc_d = ~a;    c_d = '0; c_flag_d = 1'b0; o_flag_d = 1'b0; end
      OP_OR:  begin acc_d = a | b; c_d = '0; c_flag_d = 1'b0; o_flag_d = 1'b0; end
      OP_XOR: begin acc_d = a ^ b; c_d = '0; c_flag_d = 1'b0; o_flag_d = 1'b0; end
      OP_NEG: begin
        acc_d    = '0 - a;
        c_d      = '0;
        c_flag_d = (a != '0);
        o_flag_d = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_SHL: begin
        acc_d = {a[WIDTH-2:0], 1'b0}; c_d = '0;
        c_flag_d = a[WIDTH-1]; o_flag_d = a[WIDTH-1] ^ a[WIDTH-2];
      end
      OP_SHR: begin
        acc_d = {1'b0, a[WIDTH-1:1]}; c_d = '0;
        c_flag_d = a[0]; o_flag_d = a[WIDTH-1];
      end
      OP_TEST: begin
        acc_wr   = 1'b0;
        z_flag_d = ((a & b) == '0);
      end
      default: acc_wr = 1'b0;
    endcase
    if (acc_wr) z_flag_d = (acc_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q    <= '0;
      c_q      <= '0;
      c_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
      o_flag_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      c_q      <= c_d;
      c_flag_q <= c_flag_d;
      z_flag_q <= z_flag_d;
      o_flag_q <= o_flag_d;
    end
  end

  assign acc    = acc_q;
  assign c      = c_q;
  assign c_flag = c_flag_q;
  assign z_flag = z_flag_q;
  assign o_flag = o_flag_q;
endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors from the operation table plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_alu;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic [7:0]  op;
  logic        cf;
  logic        c_flag, z_flag, o_flag;
  logic [15:0] acc, c;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_acc, m_c;
  logic        m_cf, m_zf, m_of;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic        cf;
    logic [34:0] exp;
  } vec_t;

  alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .cf(cf),
    .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .acc(acc), .c(c)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] ex(input logic [15:0] acc_e, input logic [15:0] c_e,
                                     input logic cf_e, input logic zf_e, input logic of_e);
    return {acc_e, c_e, cf_e, zf_e, of_e};
  endfunction

  // Reference model: operation table evaluated with plain integer arithmetic.
  task automatic model_update(input logic rn, input logic [15:0] ia, input logic [15:0] ib,
                              input logic [7:0] iop, input logic icf);
    int ua, ub, sa, sb, r, sr, a8, b8, ci;
    longint p;
    logic [15:0] nacc;
    bit wr;
    if (!rn) begin
      m_acc = '0; m_c = '0; m_cf = 0; m_zf = 0; m_of = 0;
      return;
    end
    ua = int'(ia); ub = int'(ib);
    sa = int'($signed(ia)); sb = int'($signed(ib));
    a8 = ua % 256; b8 = ub % 256;
    wr = 1;
    nacc = m_acc;
    case (iop)
      8'h01, 8'h02: begin
        ci = (iop == 8'h02) ? int'(icf) : 0;
        r = ua + ub + ci; sr = sa + sb + ci;
        nacc = r[15:0]; m_c = '0; m_cf = (r > 65535); m_of = (sr > 32767) || (sr < -32768);
      end
      8'h03, 8'h04, 8'h09: begin
        ci = (iop == 8'h04) ? int'(icf) : 0;
        r = ua - ub - ci; sr = sa - sb - ci;
        m_cf = (r < 0); m_of = (sr > 32767) || (sr < -32768);
        if (iop == 8'h09) begin
          wr = 0; m_zf = (r[15:0] == 16'h0000);
        end else begin
          nacc = r[15:0]; m_c = '0;
        end
      end
      8'h05: begin nacc = 16'(a8 * b8); m_c = '0; m_cf = 0; m_of = 0; end
      8'h06: begin
        p = longint'(ua) * longint'(ub);
        nacc = p[15:0]; m_c = p[31:16]; m_cf = (p[31:16] != 0); m_of = (p[31:16] != 0);
      end
      8'h07: begin
        m_c = '0; m_cf = 0;
        if (b8 == 0) begin nacc = 16'(a8 * 256 + 255); m_of = 1; end
        else begin nacc = 16'((a8 % b8) * 256 + a8 / b8); m_of = 0; end
      end
      8'h08: begin
        m_cf = 0;
        if (ub == 0) begin nacc = 16'hFFFF; m_c = ia; m_of = 1; end
        else begin nacc = 16'(ua / ub); m_c = 16'(ua % ub); m_of = 0; end
      end
      8'h0A: begin nacc = ia & ib; m_c = '0; m_cf = 0; m_of = 0; end
      8'h0C: begin nacc = ~ia;     m_c = '0; m_cf = 0; m_of = 0; end
      8'h0D: begin nacc = ia | ib; m_c = '0; m_cf = 0; m_of = 0; end
      8'h10: begin nacc = ia ^ ib; m_c = '0; m_cf = 0; m_of = 0; end
      8'h0B: begin
        nacc = 16'((65536 - ua) % 65536); m_c = '0; m_cf = (ua != 0); m_of = (ua == 32768);
      end
      8'h0E: begin
        nacc = 16'((ua * 2) % 65536); m_c = '0; m_cf = (ua >= 32768);
        m_of = (ua >= 32768) != (((ua / 16384) % 2) == 1);
      end
      8'h0F: begin
        nacc = 16'(ua / 2); m_c = '0; m_cf = (ua % 2 == 1); m_of = (ua >= 32768);
      end
      8'h11: begin wr = 0; m_zf = ((ia & ib) == 16'h0000); end
      default: wr = 0;
    endcase
    if (wr) begin
      m_acc = nacc; m_zf = (nacc == 16'h0000);
    end
  endtask

  task automatic step(input logic rn, input logic [15:0] ia, input logic [15:0] ib,
                      input logic [7:0] iop, input logic icf);
    reset = rn; a = ia; b = ib; op = iop; cf = icf;
    @(posedge clk);
    model_update(rn, ia, ib, iop, icf);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 16'h0005, 16'h0007, 8'h01, 1'b0);
    checks++;
    if ({acc, c, c_flag, z_flag, o_flag} !== 35'h0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", {acc, c, c_flag, z_flag, o_flag}, 35'h0);
    end
    step(1'b1, 16'h0005, 16'h0007, 8'h01, 1'b0);
    checks++;
    if ({acc, c, c_flag, z_flag, o_flag} !== ex(16'h000C, 16'h0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", {acc, c, c_flag, z_flag, o_flag},
               ex(16'h000C, 16'h0, 0, 0, 0));
    end
  endtask

  task automatic test_add_adc();
    vec_t v[4];
    v[0] = '{16'hFFFF, 16'h0001, 8'h01, 1'b0, ex(16'h0000, 16'h0, 1, 1, 0)};
    v[1] = '{16'h7FFF, 16'h0000, 8'h02, 1'b1, ex(16'h8000, 16'h0, 0, 0, 1)};
    v[2] = '{16'h8000, 16'h8000, 8'h01, 1'b0, ex(16'h0000, 16'h0, 1, 1, 1)};
    v[3] = '{16'h1234, 16'h1111, 8'h01, 1'b1, ex(16'h2345, 16'h0, 0, 0, 0)};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, v[i].a, v[i].b, v[i].op, v[i].cf);
      checks++;
      if ({acc, c, c_flag, z_flag, o_flag} !== v[i].exp) begin
        failures++;
        $display("FAIL add[%0d] got=%h exp=%h", i, {acc, c, c_flag, z_flag, o_flag}, v[i].exp);
      end
    end
  endtask

  task automatic test_sub_cmp();
    vec_t v[4];
    v[0] = '{16'h0001, 16'h0002, 8'h03, 1'b0, ex(16'hFFFF, 16'h0, 1, 0, 0)};
    v[1] = '{16'h1234, 16'h1234, 8'h09, 1'b0, ex(16'hFFFF, 16'h0, 0, 1, 0)};
    v[2] = '{16'h0000, 16'h0000, 8'h04, 1'b1, ex(16'hFFFF, 16'h0, 1, 0, 0)};
    v[3] = '{16'h8000, 16'h0001, 8'h03, 1'b0, ex(16'h7FFF, 16'h0, 0, 0, 1)};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, v[i].a, v[i].b, v[i].op, v[i].cf);
      checks++;
      if ({acc, c, c_flag, z_flag, o_flag} !== v[i].exp) begin
        failures++;
        $display("FAIL sub[%0d] got=%h exp=%h", i, {acc, c, c_flag, z_flag, o_flag}, v[i].exp);
      end
    end
  endtask

  task automatic test_mul_div();
    vec_t v[7];
    v[0] = '{16'hFFFF, 16'hFFFF, 8'h06, 1'b0, ex(16'h0001, 16'hFFFE, 1, 0, 1)};
    v[1] = '{16'h0064, 16'h0007, 8'h08, 1'b0, ex(16'h000E, 16'h0002, 0, 0, 0)};
    v[2] = '{16'h0064, 16'h0000, 8'h08, 1'b0, ex(16'hFFFF, 16'h0064, 0, 0, 1)};
    v[3] = '{16'h12FF, 16'h34FF, 8'h05, 1'b1, ex(16'hFE01, 16'h0, 0, 0, 0)};
    v[4] = '{16'h0064, 16'hAB07, 8'h07, 1'b0, ex(16'h020E, 16'h0, 0, 0, 0)};
    v[5] = '{16'h1234, 16'h0500, 8'h07, 1'b0, ex(16'h34FF, 16'h0, 0, 0, 1)};
    v[6] = '{16'h0100, 16'h0100, 8'h06, 1'b0, ex(16'h0000, 16'h0001, 1, 1, 1)};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, v[i].a, v[i].b, v[i].op, v[i].cf);
      checks++;
      if ({acc, c, c_flag, z_flag, o_flag} !== v[i].exp) begin
        failures++;
        $display("FAIL muldiv[%0d] got=%h exp=%h", i, {acc, c, c_flag, z_flag, o_flag}, v[i].exp);
      end
    end
  endtask

  task automatic test_logic_shift();
    vec_t v[10];
    v[0] = '{16'h8001, 16'hA5A5, 8'h0E, 1'b1, ex(16'h0002, 16'h0, 1, 0, 1)};
    v[1] = '{16'h8001, 16'hA5A5, 8'h0F, 1'b1, ex(16'h4000, 16'h0, 1, 0, 1)};
    v[2] = '{16'h00F0, 16'h0F00, 8'h11, 1'b0, ex(16'h4000, 16'h0, 1, 1, 1)};
    v[3] = '{16'h8000, 16'hA5A5, 8'h0B, 1'b1, ex(16'h8000, 16'h0, 1, 0, 1)};
    v[4] = '{16'h0000, 16'hA5A5, 8'h0B, 1'b1, ex(16'h0000, 16'h0, 0, 1, 0)};
    v[5] = '{16'hF0F0, 16'hFF00, 8'h0A, 1'b0, ex(16'hF000, 16'h0, 0, 0, 0)};
    v[6] = '{16'hF0F0, 16'hA5A5, 8'h0C, 1'b1, ex(16'h0F0F, 16'h0, 0, 0, 0)};
    v[7] = '{16'hF0F0, 16'h0F0F, 8'h0D, 1'b0, ex(16'hFFFF, 16'h0, 0, 0, 0)};
    v[8] = '{16'hFFFF, 16'hFFFF, 8'h10, 1'b0, ex(16'h0000, 16'h0, 0, 1, 0)};
    v[9] = '{16'h4000, 16'hA5A5, 8'h0E, 1'b0, ex(16'h8000, 16'h0, 0, 0, 1)};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, v[i].a, v[i].b, v[i].op, v[i].cf);
      checks++;
      if ({acc, c, c_flag, z_flag, o_flag} !== v[i].exp) begin
        failures++;
        $display("FAIL logic[%0d] got=%h exp=%h", i, {acc, c, c_flag, z_flag, o_flag}, v[i].exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] hold_ops[4];
    logic [34:0] snap;
    hold_ops[0] = 8'h00; hold_ops[1] = 8'h20; hold_ops[2] = 8'h12; hold_ops[3] = 8'hFF;
    snap = {m_acc, m_c, m_cf, m_zf, m_of};
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        step(1'b1, 16'($urandom), 16'($urandom), hold_ops[k], 1'($urandom));
        checks++;
        if ({acc, c, c_flag, z_flag, o_flag} !== snap) begin
          failures++;
          $display("FAIL hold op=%h cyc=%0d got=%h exp=%h", hold_ops[k], j,
                   {acc, c, c_flag, z_flag, o_flag}, snap);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb;
    logic [7:0]  rop;
    logic        rn;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 18) rop = 8'(sel);
      else if (sel == 18) rop = 8'h12;
      else rop = 8'($urandom_range(8'h13, 8'hFF));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: rb[7:0] = 8'h00;
        2: ra = 16'h8000;
        default: ;
      endcase
      rn = ($urandom_range(0, 24) != 0);
      step(rn, ra, rb, rop, 1'($urandom));
      checks++;
      if ({acc, c, c_flag, z_flag, o_flag} !== {m_acc, m_c, m_cf, m_zf, m_of}) begin
        failures++;
        $display("FAIL random[%0d] rst_n=%b op=%h a=%h b=%h got=%h exp=%h", i, rn, rop, ra, rb,
                 {acc, c, c_flag, z_flag, o_flag}, {m_acc, m_c, m_cf, m_zf, m_of});
      end
    end
  endtask

  initial begin
    reset = 1'b0; a = '0; b = '0; op = '0; cf = 1'b0;
    m_acc = '0; m_c = '0; m_cf = 0; m_zf = 0; m_of = 0;
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_mul_div();
    test_logic_shift();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
